// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: requester ports, DM port and status signals of the two-port DM arbiter
interface dm_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          m0_req, m0_we, m0_ack, m0_err;
  logic [1:0]    m0_size;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_ack, m1_err;
  logic [1:0]    m1_size;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          dm_we;
  logic [1:0]    dm_memdst;
  logic [AW-1:0] dm_a;
  logic [DW-1:0] dm_wd, dm_rd;
  logic          busy, owner;
  modport slave (
    input  m0_req, m0_we, m0_size, m0_addr, m0_wdata,
    output m0_ack, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_size, m1_addr, m1_wdata,
    output m1_ack, m1_rdata, m1_err,
    output dm_we, dm_memdst, dm_a, dm_wd,
    input  dm_rd,
    output busy, owner
  );
  modport master (
    output m0_req, m0_we, m0_size, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata, m0_err,
    output m1_req, m1_we, m1_size, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata, m1_err,
    input  dm_we, dm_memdst, dm_a, dm_wd,
    output dm_rd,
    input  busy, owner
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin two-port arbiter driving one aligned DM access per grant
module dm_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  dm_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  state_e        state_q, state_d;
  logic          prio_q, prio_d, owner_q, owner_d, we_q, we_d, err_q, err_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic          gnt, valid, acc, resp;
  always_comb begin
    gnt = (bus.m0_req && bus.m1_req) ? prio_q : bus.m1_req;
    valid = size_q != 2'b11 &&
            (size_q == 2'b00 ? addr_q[1:0] == 2'b00 : size_q == 2'b01 ? !addr_q[0] : 1'b1);
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.m0_req || bus.m1_req) begin
        state_d = ACCESS;
        owner_d = gnt;
        prio_d  = !gnt;
        we_d    = gnt ? bus.m1_we    : bus.m0_we;
        size_d  = gnt ? bus.m1_size  : bus.m0_size;
        addr_d  = gnt ? bus.m1_addr  : bus.m0_addr;
        wdata_d = gnt ? bus.m1_wdata : bus.m0_wdata;
      end
      ACCESS: begin
        state_d = RESP;
        err_d   = !valid;
        rdata_d = (valid && !we_q) ? bus.dm_rd : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // reset gates the DM strobe and the ack so an interrupted access has no effect
  assign acc           = state_q == ACCESS;
  assign resp          = state_q == RESP && !Reset;
  assign bus.dm_we     = acc && valid && we_q && !Reset;
  assign bus.dm_memdst = acc ? size_q : 2'b00;
  assign bus.dm_a      = acc ? addr_q : '0;
  assign bus.dm_wd     = acc ? wdata_q : '0;
  assign bus.m0_ack    = resp && !owner_q;
  assign bus.m1_ack    = resp && owner_q;
  assign bus.m0_rdata  = bus.m0_ack ? rdata_q : '0;
  assign bus.m1_rdata  = bus.m1_ack ? rdata_q : '0;
  assign bus.m0_err    = bus.m0_ack && err_q;
  assign bus.m1_err    = bus.m1_ack && err_q;
  assign bus.busy      = (acc || state_q == RESP) && !Reset;
  assign bus.owner     = owner_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed checks of dm_arbiter against a small byte-addressed DM model
module tb_dm_arbiter;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int npass = 0, ntot = 0, we_cnt = 0;
  logic [7:0] mem [0:63];
  logic [5:0] ra;
  logic [31:0] rw;
  dm_arbiter_if #(.AW(12), .DW(32)) bus ();
  dm_arbiter #(.AW(12), .DW(32)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  always_comb begin
    ra = bus.dm_a[5:0];
    rw = {mem[ra + 6'd3], mem[ra + 6'd2], mem[ra + 6'd1], mem[ra]};
    bus.dm_rd = bus.dm_memdst == 2'b00 ? rw :
                bus.dm_memdst == 2'b01 ? {{16{rw[15]}}, rw[15:0]} :
                bus.dm_memdst == 2'b10 ? {{24{rw[7]}}, rw[7:0]} : 32'h0;
  end
  always @(posedge Clk) if (bus.dm_we) begin
    we_cnt <= we_cnt + 1;
    mem[bus.dm_a[5:0]] <= bus.dm_wd[7:0];
    if (bus.dm_memdst != 2'b10) mem[bus.dm_a[5:0] + 6'd1] <= bus.dm_wd[15:8];
    if (bus.dm_memdst == 2'b00) begin
      mem[bus.dm_a[5:0] + 6'd2] <= bus.dm_wd[23:16];
      mem[bus.dm_a[5:0] + 6'd3] <= bus.dm_wd[31:24];
    end
  end
  function automatic logic [31:0] mword(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic xact(input bit p, input bit we, input logic [1:0] sz, input logic [11:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output bit er,
                      output int lat, output bit ack2);
    if (p) begin
      bus.m1_req = 1; bus.m1_we = we; bus.m1_size = sz; bus.m1_addr = a; bus.m1_wdata = wd;
    end else begin
      bus.m0_req = 1; bus.m0_we = we; bus.m0_size = sz; bus.m0_addr = a; bus.m0_wdata = wd;
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(p ? bus.m1_ack : bus.m0_ack) && lat < 10);
    rd = p ? bus.m1_rdata : bus.m0_rdata;
    er = p ? bus.m1_err : bus.m0_err;
    bus.m0_req = 0;
    bus.m1_req = 0;
    tick();
    ack2 = p ? bus.m1_ack : bus.m0_ack;
  endtask
  logic [31:0] rd;
  bit er, a2;
  int lat, dbl, n;
  bit ord [$];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem[i] = 8'hAA;
    {bus.m0_req, bus.m0_we, bus.m0_size, bus.m0_addr, bus.m0_wdata} = '0;
    {bus.m1_req, bus.m1_we, bus.m1_size, bus.m1_addr, bus.m1_wdata} = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_acks", {30'd0, bus.m1_ack, bus.m0_ack}, 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_dm_we", 32'(bus.dm_we), 0);
    Reset = 0;
    tick();
    // word write from port 0, cycle by cycle
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_size = 2'b00; bus.m0_addr = 12'h010; bus.m0_wdata = 32'h12345678;
    tick();
    chk("w_dm_we", 32'(bus.dm_we), 1);
    chk("w_dm_a", 32'(bus.dm_a), 32'h010);
    chk("w_dm_memdst", 32'(bus.dm_memdst), 0);
    chk("w_dm_wd", bus.dm_wd, 32'h12345678);
    chk("w_busy", 32'(bus.busy), 1);
    chk("w_ack_early", 32'(bus.m0_ack), 0);
    tick();
    chk("w_ack", 32'(bus.m0_ack), 1);
    chk("w_err", 32'(bus.m0_err), 0);
    chk("w_we_off", 32'(bus.dm_we), 0);
    chk("w_dm_a_off", 32'(bus.dm_a), 0);
    bus.m0_req = 0;
    tick();
    chk("w_ack_one", 32'(bus.m0_ack), 0);
    chk("w_idle", 32'(bus.busy), 0);
    chk("w_mem", mword(16), 32'h12345678);
    chk("w_we_cnt", we_cnt, 1);
    // port 1 byte write then sign-extended byte read
    xact(1, 1, 2'b10, 12'h013, 32'h00000080, rd, er, lat, a2);
    chk("b_wr_err", 32'(er), 0);
    chk("b_wr_owner", 32'(bus.owner), 1);
    xact(1, 0, 2'b10, 12'h013, 32'h0, rd, er, lat, a2);
    chk("b_rd_data", rd, 32'hFFFFFF80);
    chk("b_rd_err", 32'(er), 0);
    chk("b_rd_lat", lat, 2);
    chk("b_rd_ack_one", 32'(a2), 0);
    chk("b_we_cnt", we_cnt, 2);
    // both ports continuously requesting
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_size = 2'b00; bus.m0_addr = 12'h000;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_size = 2'b00; bus.m1_addr = 12'h010;
    dbl = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.m0_ack && bus.m1_ack) dbl++;
      if (bus.m0_ack) begin ord.push_back(0); chk("rr_owner0", 32'(bus.owner), 0); chk("rr_rd0", bus.m0_rdata, 32'hAAAAAAAA); end
      if (bus.m1_ack) begin ord.push_back(1); chk("rr_owner1", 32'(bus.owner), 1); chk("rr_rd1", bus.m1_rdata, 32'h80345678); end
    end
    bus.m0_req = 0;
    bus.m1_req = 0;
    chk("rr_count", ord.size(), 4);
    chk("rr_double_ack", dbl, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 32'(i < ord.size() ? ord[i] : 1'bx), 32'(i % 2));
    tick();
    tick();
    // rejected accesses from port 0
    xact(0, 1, 2'b01, 12'h011, 32'h0000BEEF, rd, er, lat, a2);
    chk("e_half_err", 32'(er), 1);
    chk("e_half_rd", rd, 0);
    xact(0, 0, 2'b00, 12'h002, 32'h0, rd, er, lat, a2);
    chk("e_word_err", 32'(er), 1);
    chk("e_word_rd", rd, 0);
    xact(0, 1, 2'b11, 12'h010, 32'hFFFFFFFF, rd, er, lat, a2);
    chk("e_size_err", 32'(er), 1);
    chk("e_size_rd", rd, 0);
    chk("e_we_cnt", we_cnt, 2);
    chk("e_mem", mword(16), 32'h80345678);
    // reset during the ACCESS cycle of a write, prio is 1 here
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_size = 2'b00; bus.m0_addr = 12'h020; bus.m0_wdata = 32'hDEADBEEF;
    tick();
    chk("r_in_access", 32'(bus.dm_a), 32'h020);
    Reset = 1;
    bus.m0_req = 0;
    #1;
    chk("r_dm_we", 32'(bus.dm_we), 0);
    chk("r_busy", 32'(bus.busy), 0);
    tick();
    Reset = 0;
    chk("r_no_ack", 32'(bus.m0_ack), 0);
    chk("r_owner", 32'(bus.owner), 0);
    tick();
    chk("r_idle", 32'(bus.busy), 0);
    chk("r_mem", mword(32), 0);
    chk("r_we_cnt", we_cnt, 2);
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_size = 2'b10; bus.m0_addr = 12'h000;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_size = 2'b10; bus.m1_addr = 12'h000;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.m0_ack || bus.m1_ack) && n < 10);
    chk("r_prio_ack0", 32'(bus.m0_ack), 1);
    chk("r_prio_ack1", 32'(bus.m1_ack), 0);
    chk("r_prio_lat", n, 2);
    bus.m0_req = 0;
    bus.m1_req = 0;
    tick();
    tick();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
